// File: rtl/uart_apb_ctrl.sv
// rtl/uart_apb_ctrl.sv - APB-slave UART with TX/RX FIFOs, programmable divisor, parity and IRQ
// Optional internal loopback (CTRL[7]) is built only when UART_LOOPBACK_EN is defined.

module uart_apb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         push_ok, pop_ok;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign rdata   = mem[rptr[AW-1:0]];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
    end
  end
endmodule

module uart_apb_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int RST_DIV    = 433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        RX_IN,
  output logic        TX_OUT,
  output logic        IRQ
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
`ifdef UART_LOOPBACK_EN
  localparam logic [7:0] CTRL_MASK = 8'hFF;
`else
  localparam logic [7:0] CTRL_MASK = 8'h7F;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [7:0]       ctrl;
  logic [DIV_W-1:0] div;
  logic             ovr, par_err, frm_err;
  logic             setup, access, wr_acc;
  logic [1:0]       reg_sel;
  logic [2:0]       w1c;
  logic [31:0]      status, rd_mux;
  logic             unused_apb;

  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_BITS-1:0] tx_head;
  logic [CW-1:0]        tx_count;
  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_BITS-1:0] rx_head;
  logic [CW-1:0]        rx_count;

  state_t               tx_state, tx_state_n, rx_state, rx_state_n;
  logic [DIV_W-1:0]     tx_cnt, rx_cnt;
  logic [3:0]           tx_bit, rx_bit;
  logic [DATA_BITS-1:0] tx_sh, rx_sh;
  logic                 tx_par, tx_busy, tx_tick;
  logic                 rx_src, rx_s1, rx_s2, rx_prev, rx_pbit, rx_tick;

  assign setup      = PSEL && !PENABLE;
  assign access     = PSEL && PENABLE;
  assign wr_acc     = access && PWRITE;
  assign reg_sel    = PADDR[3:2];
  assign PREADY     = 1'b1;
  assign unused_apb = ^{PADDR[1:0], PWDATA};
  assign w1c        = (wr_acc && reg_sel == 2'd1) ? PWDATA[7:5] : 3'b000;

  // PSLVERR was decided at setup; since only this port pushes TX and pops RX, that decision still holds.
  assign tx_push = wr_acc && reg_sel == 2'd0 && !PSLVERR;
  assign rx_pop  = access && !PWRITE && reg_sel == 2'd0 && !PSLVERR;

  uart_apb_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .wdata(PWDATA[DATA_BITS-1:0]), .pop(tx_pop),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  uart_apb_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .wdata(rx_sh), .pop(rx_pop),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  always_comb begin
    status       = '0;
    status[0]    = tx_full;
    status[1]    = tx_empty;
    status[2]    = rx_full;
    status[3]    = rx_empty;
    status[4]    = tx_busy;
    status[5]    = ovr;
    status[6]    = par_err;
    status[7]    = frm_err;
    status[15:8] = 8'(rx_count);
    case (reg_sel)
      2'd0:    rd_mux = rx_empty ? 32'd0 : 32'(rx_head);
      2'd1:    rd_mux = status;
      2'd2:    rd_mux = 32'(ctrl);
      default: rd_mux = 32'(div);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
      ctrl    <= '0;
      div     <= DIV_W'(RST_DIV);
      ovr     <= 1'b0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
      IRQ     <= 1'b0;
    end else begin
      if (setup) begin
        PRDATA  <= PWRITE ? 32'd0 : rd_mux;
        PSLVERR <= (reg_sel == 2'd0) && (PWRITE ? tx_full : rx_empty);
      end else if (!access) begin
        PSLVERR <= 1'b0;
      end
      if (wr_acc && reg_sel == 2'd2) ctrl <= PWDATA[7:0] & CTRL_MASK;
      if (wr_acc && reg_sel == 2'd3) div  <= PWDATA[DIV_W-1:0];
      // A same-cycle set event beats the W1C clear.
      ovr     <= (ovr     && !w1c[0]) || (rx_push && rx_full);
      par_err <= (par_err && !w1c[1]) || (rx_push && ctrl[2] && (rx_pbit != (^rx_sh ^ ctrl[3])));
      frm_err <= (frm_err && !w1c[2]) || (rx_push && !rx_s2);
      IRQ     <= (ctrl[4] && !rx_empty) || (ctrl[5] && tx_empty && !tx_busy)
              || (ctrl[6] && (ovr || par_err || frm_err));
    end
  end

  assign tx_busy = (tx_state != S_IDLE);
  assign tx_tick = (tx_cnt == '0);

  always_comb begin
    tx_state_n = tx_state;
    tx_pop     = 1'b0;
    case (tx_state)
      S_IDLE:   if (ctrl[0] && !tx_empty) begin tx_state_n = S_START; tx_pop = 1'b1; end
      S_START:  if (tx_tick) tx_state_n = S_DATA;
      S_DATA:   if (tx_tick && tx_bit == LAST_BIT) tx_state_n = ctrl[2] ? S_PARITY : S_STOP;
      S_PARITY: if (tx_tick) tx_state_n = S_STOP;
      S_STOP:   if (tx_tick) begin
                  if (ctrl[0] && !tx_empty) begin tx_state_n = S_START; tx_pop = 1'b1; end
                  else tx_state_n = S_IDLE;
                end
      default:  tx_state_n = S_IDLE;
    endcase
    case (tx_state)
      S_START:  TX_OUT = 1'b0;
      S_DATA:   TX_OUT = tx_sh[0];
      S_PARITY: TX_OUT = tx_par;
      default:  TX_OUT = 1'b1;
    endcase
  end

  // Bit timers count down from a value loaded at each bit boundary, so DIV writes apply from the next bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= DIV_W'(RST_DIV);
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= (tx_state == S_IDLE || tx_tick) ? div : tx_cnt - 1'b1;
      if (tx_pop) begin
        tx_sh  <= tx_head;
        tx_bit <= '0;
        tx_par <= ^tx_head ^ ctrl[3];
      end else if (tx_state == S_DATA && tx_tick) begin
        tx_sh  <= tx_sh >> 1;
        tx_bit <= tx_bit + 1'b1;
      end
    end
  end

`ifdef UART_LOOPBACK_EN
  assign rx_src = ctrl[7] ? TX_OUT : RX_IN;
`else
  assign rx_src = RX_IN;
`endif
  assign rx_tick = (rx_cnt == '0);

  always_comb begin
    rx_state_n = rx_state;
    rx_push    = 1'b0;
    case (rx_state)
      S_IDLE:   if (ctrl[1] && rx_prev && !rx_s2) rx_state_n = S_START;
      S_START:  if (rx_tick) rx_state_n = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:   if (rx_tick && rx_bit == LAST_BIT) rx_state_n = ctrl[2] ? S_PARITY : S_STOP;
      S_PARITY: if (rx_tick) rx_state_n = S_STOP;
      S_STOP:   if (rx_tick) begin rx_state_n = S_IDLE; rx_push = 1'b1; end
      default:  rx_state_n = S_IDLE;
    endcase
  end

  // While idle the timer is preloaded with DIV/2 so START ends at mid start-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_pbit  <= 1'b0;
    end else begin
      rx_s1    <= rx_src;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_n;
      if (rx_state == S_IDLE) rx_cnt <= div >> 1;
      else                    rx_cnt <= rx_tick ? div : rx_cnt - 1'b1;
      if (rx_state == S_START) rx_bit <= '0;
      if (rx_state == S_DATA && rx_tick) begin
        rx_sh  <= {rx_s2, rx_sh[DATA_BITS-1:1]};
        rx_bit <= rx_bit + 1'b1;
      end
      if (rx_state == S_PARITY && rx_tick) rx_pbit <= rx_s2;
    end
  end
endmodule

// File: tb/tb_uart_apb_ctrl.sv
// tb/tb_uart_apb_ctrl.sv - scoreboard bench for uart_apb_ctrl with a queue-based reference model
module tb_uart_apb_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [3:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        RX_IN = 1'b1;
  logic        TX_OUT, IRQ;

  uart_apb_ctrl dut (
    .clk(clk), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .RX_IN(RX_IN), .TX_OUT(TX_OUT), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

`ifdef UART_LOOPBACK_EN
  localparam logic [7:0] CTRL_MASK = 8'hFF;
`else
  localparam logic [7:0] CTRL_MASK = 8'h7F;
`endif

  typedef struct { logic wr; logic [31:0] data; logic err; string name; } apb_exp_t;
  typedef struct { logic [7:0] ch; logic par_en; logic par_odd; } tx_exp_t;

  apb_exp_t   apb_q[$];
  tx_exp_t    tx_q[$];
  logic [7:0] m_rxq[$];
  logic [7:0] m_ctrl = 8'h00;
  int         m_div = 433;
  logic       m_ovr = 1'b0, m_par = 1'b0, m_frm = 1'b0;
  int         cur_div = 433;
  int         tx_sent = 0, tx_done = 0;
  int         n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // APB scoreboard monitor: every completed transfer is checked against the next expectation.
  always @(negedge clk) begin
    if (!rst && PSEL && PENABLE) begin
      if (apb_q.size() == 0) begin
        chk("apb_unexpected_transfer", 32'd1, 32'd0);
      end else begin
        apb_exp_t e;
        e = apb_q.pop_front();
        if (!e.wr) chk({e.name, "_rdata"}, PRDATA, e.data);
        chk({e.name, "_pslverr"}, 32'(PSLVERR), 32'(e.err));
      end
    end
  end

  // TX monitor: each frame is checked cycle by cycle against the waveform implied by the queued character.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && TX_OUT === 1'b0) begin
        if (tx_q.size() == 0) begin
          chk("tx_unexpected_frame", 32'd1, 32'd0);
          for (int t = 0; t < 2000 && TX_OUT !== 1'b1; t++) @(negedge clk);
        end else begin
          tx_exp_t    e;
          logic [11:0] bits;
          int         nb, bad;
          bit         aborted;
          e = tx_q.pop_front();
          bits = '0;
          bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) bits[1+i] = e.ch[i];
          nb = 9;
          if (e.par_en) begin bits[nb] = ^e.ch ^ e.par_odd; nb++; end
          bits[nb] = 1'b1;
          nb++;
          bad = 0;
          aborted = 0;
          for (int c = 0; c < nb * (cur_div + 1); c++) begin
            if (c > 0) @(negedge clk);
            if (rst) begin aborted = 1; break; end
            if (TX_OUT !== bits[c / (cur_div + 1)]) bad++;
          end
          if (!aborted) begin
            chk($sformatf("tx_frame_0x%02h_bad_cycles", e.ch), 32'(bad), 32'd0);
            tx_done++;
          end
        end
      end
    end
  end

  task automatic apb(input logic wr, input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d, input logic err, input string name);
    apb_exp_t e;
    e.wr = 1'b1; e.data = '0; e.err = err; e.name = name;
    apb_q.push_back(e);
    apb(1'b1, a, d);
  endtask

  task automatic rd_reg(input logic [3:0] a, input logic [31:0] exp, input logic err, input string name);
    apb_exp_t e;
    e.wr = 1'b0; e.data = exp; e.err = err; e.name = name;
    apb_q.push_back(e);
    apb(1'b0, a, 32'd0);
  endtask

  function automatic logic [31:0] status_exp();
    logic [31:0] s;
    s = '0;
    s[1] = 1'b1;
    s[2] = (m_rxq.size() == 8);
    s[3] = (m_rxq.size() == 0);
    s[5] = m_ovr;
    s[6] = m_par;
    s[7] = m_frm;
    s[15:8] = 8'(m_rxq.size());
    return s;
  endfunction

  task automatic set_ctrl(input logic [7:0] v);
    wr_reg(4'h8, 32'(v), 1'b0, "ctrl_wr");
    m_ctrl = v & CTRL_MASK;
  endtask

  task automatic set_div(input int v);
    wr_reg(4'hC, 32'(v), 1'b0, "div_wr");
    m_div = v;
    cur_div = v;
  endtask

  task automatic rd_status();
    rd_reg(4'h4, status_exp(), 1'b0, "status");
  endtask

  task automatic rd_data();
    logic [7:0] c;
    if (m_rxq.size() == 0) rd_reg(4'h0, 32'd0, 1'b1, "data_empty");
    else begin
      c = m_rxq.pop_front();
      rd_reg(4'h0, 32'(c), 1'b0, "data");
    end
  endtask

  task automatic w1c(input logic [2:0] bits);
    wr_reg(4'h4, {24'd0, bits, 5'd0}, 1'b0, "status_w1c");
    if (bits[0]) m_ovr = 1'b0;
    if (bits[1]) m_par = 1'b0;
    if (bits[2]) m_frm = 1'b0;
  endtask

  task automatic chk_irq(input string name);
    logic exp;
    repeat (3) @(posedge clk);
    #1;
    exp = (m_ctrl[4] && m_rxq.size() > 0) || m_ctrl[5] || (m_ctrl[6] && (m_ovr || m_par || m_frm));
    chk(name, 32'(IRQ), 32'(exp));
  endtask

  task automatic send_tx(input logic [7:0] c);
    tx_exp_t e;
    e.ch = c; e.par_en = m_ctrl[2]; e.par_odd = m_ctrl[3];
    tx_q.push_back(e);
    tx_sent++;
    wr_reg(4'h0, ($urandom & 32'hFFFF_FF00) | 32'(c), 1'b0, "data_wr");
  endtask

  task automatic wait_tx();
    int t;
    t = 0;
    while (tx_done < tx_sent && t < 20000) begin @(posedge clk); t++; end
    if (t >= 20000) chk("tx_timeout", 32'(tx_done), 32'(tx_sent));
  endtask

  task automatic hold(input logic b);
    RX_IN = b;
    repeat (m_div + 1) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] ch, input bit bad_par, input bit stop);
    @(posedge clk); #1;
    hold(1'b0);
    for (int i = 0; i < 8; i++) hold(ch[i]);
    if (m_ctrl[2]) hold(^ch ^ m_ctrl[3] ^ bad_par);
    hold(stop);
    hold(1'b1);
    hold(1'b1);
    if (m_rxq.size() < 8) m_rxq.push_back(ch);
    else m_ovr = 1'b1;
    if (!stop) m_frm = 1'b1;
    if (m_ctrl[2] && bad_par) m_par = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c;
    logic [31:0] s;
    int t;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_out", 32'(TX_OUT), 32'd1);
    chk("rst_irq", 32'(IRQ), 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_pslverr", 32'(PSLVERR), 32'd0);
    rst = 1'b0;
    rd_status();
    rd_reg(4'h8, 32'd0, 1'b0, "ctrl_rst");
    rd_reg(4'hC, 32'd433, 1'b0, "div_rst");

    // Single known frame, then random frames with random parity settings.
    set_div(3);
    set_ctrl(8'h01);
    send_tx(8'hA5);
    wait_tx();
    rd_status();
    chk_irq("irq_tx_idle_disabled");

    set_ctrl(8'h01 | 8'($urandom_range(1)) << 2 | 8'($urandom_range(1)) << 3 | 8'h20);
    for (int i = 0; i < 4; i++) send_tx(8'($urandom));
    wait_tx();
    rd_status();
    chk_irq("irq_tx_empty");

    // Fill the TX FIFO with transmission disabled; the ninth write must be refused.
    set_ctrl(8'h00 | 8'($urandom_range(1)) << 2 | 8'($urandom_range(1)) << 3);
    for (int i = 0; i < 8; i++) send_tx(8'($urandom));
    wr_reg(4'h0, 32'h5A, 1'b1, "data_wr_full");
    s = status_exp();
    s[0] = 1'b1;
    s[1] = 1'b0;
    rd_reg(4'h4, s, 1'b0, "status_tx_full");
    set_ctrl(m_ctrl | 8'h01);
    wait_tx();
    rd_status();

    // CTRL[7] only sticks when loopback is built in.
    set_ctrl(8'h97);
    rd_reg(4'h8, 32'(m_ctrl), 1'b0, "ctrl_loopback_bit");
`ifdef UART_LOOPBACK_EN
    set_div(7);
    send_tx(8'h3C);
    wait_tx();
    repeat (20) @(posedge clk);
    m_rxq.push_back(8'h3C);
    rd_status();
    chk_irq("irq_loopback_rx");
    rd_data();
`endif

    set_div(15);
    set_ctrl(8'h16);
    send_rx(8'h3C, 1'b0, 1'b1);
    rd_status();
    chk_irq("irq_rx_even_parity");
    rd_data();
    chk_irq("irq_rx_drained");

    // Overrun: nine characters into an eight-entry FIFO.
    set_ctrl(8'h02);
    for (int i = 1; i <= 9; i++) send_rx(8'(i), 1'b0, 1'b1);
    rd_status();
    for (int i = 0; i < 9; i++) rd_data();
    w1c(3'b001);
    rd_status();

    // Framing error still stores the character.
    send_rx(8'h55, 1'b0, 1'b0);
    rd_status();
    w1c(3'b100);
    rd_status();
    rd_data();

    // Random frames with injected parity/stop errors and interleaved reads.
    for (int k = 0; k < 14; k++) begin
      if (k % 7 == 0)
        set_ctrl(8'h42 | 8'($urandom_range(1)) << 2 | 8'($urandom_range(1)) << 3 | 8'($urandom_range(1)) << 4);
      send_rx(8'($urandom), ($urandom_range(3) == 0), ($urandom_range(4) != 0));
      if ($urandom_range(1) == 1) rd_data();
      if (k % 3 == 0) begin
        rd_status();
        chk_irq("irq_random_rx");
      end
    end
    while (m_rxq.size() > 0) rd_data();
    rd_status();
    w1c(3'b111);
    rd_status();
    chk_irq("irq_after_clear");

    // A one-cycle glitch must be rejected and leave RX ready for a real frame.
    set_ctrl(8'h02);
    @(posedge clk); #1;
    RX_IN = 1'b0;
    @(posedge clk); #1;
    RX_IN = 1'b1;
    repeat (40) @(posedge clk);
    rd_status();
    send_rx(8'hA7, 1'b0, 1'b1);
    rd_status();
    rd_data();

    // Reset in the middle of a TX frame.
    set_div(3);
    set_ctrl(8'h01);
    send_tx(8'hC3);
    send_tx(8'h18);
    t = 0;
    while (TX_OUT !== 1'b0 && t < 200) begin @(posedge clk); t++; end
    chk("tx_start_seen", 32'(t < 200), 32'd1);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("tx_out_async_rst", 32'(TX_OUT), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tx_q.delete();
    tx_sent = tx_done;
    m_rxq.delete();
    m_ctrl = 8'h00; m_div = 433; cur_div = 433;
    m_ovr = 1'b0; m_par = 1'b0; m_frm = 1'b0;
    rd_status();
    rd_reg(4'hC, 32'd433, 1'b0, "div_after_rst");
    chk_irq("irq_after_rst");
    repeat (5) @(posedge clk);
    chk("apb_queue_drained", 32'(apb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
